// File: rtl/hls_chn_pkg.sv
`default_nettype none
//==============================================================================
// Module  : hls_chn_pkg
// Purpose : Shared definitions for the multi-channel input wait controller:
//           pointer-width helper, stall-counter saturation helper and the
//           channel index type.
// Ports   : none (package)
// Revision: 1.0 - initial release
//==============================================================================
package hls_chn_pkg;

   // Up to 8 channels are supported, so a 3-bit index covers every channel.
   typedef logic [2:0] ch_idx_t;

   localparam int c_max_cnt_w = 32;

   // Ceiling log2, used for buffer pointer widths (DEPTH is a power of two).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // All-ones value of a w-bit counter, i.e. its saturation point.
   function automatic logic [c_max_cnt_w-1:0] stall_sat(input int w);
      logic [c_max_cnt_w-1:0] v;
      if (w >= c_max_cnt_w) begin
         v = '1;
      end else begin
         v = (c_max_cnt_w'(1) << w) - c_max_cnt_w'(1);
      end
      return v;
   endfunction

endpackage : hls_chn_pkg
`default_nettype wire

// File: rtl/hls_chn_in_wait_ctrl_mc_if.sv
`default_nettype none
//==============================================================================
// Module  : hls_chn_in_wait_ctrl_mc_if
// Purpose : Bundle of the channel-side valid/ready bus and the HLS core-side
//           staged read controls of the multi-channel wait controller.
// Ports   : chn_vd/chn_dat/chn_rdy        - per-channel input handshake
//           core_wen/core_wten            - core stage enable / wait enable
//           rsci_iswt0/oswt/ld_core_psct  - per-channel core read controls
//           rsci_biwt/bdwt/ld_core_sct    - per-channel status back to core
//           core_dat/core_stall           - head data and global stall
//           slave modport : controller side, master modport : environment
// Revision: 1.0 - initial release
//==============================================================================
interface hls_chn_in_wait_ctrl_mc_if #(
   parameter int NUM_CH = 2,
   parameter int DW     = 16
) ();
   logic [NUM_CH-1:0]    chn_vd;
   logic [NUM_CH*DW-1:0] chn_dat;
   logic [NUM_CH-1:0]    chn_rdy;
   logic                 core_wen;
   logic                 core_wten;
   logic [NUM_CH-1:0]    rsci_iswt0;
   logic [NUM_CH-1:0]    rsci_oswt;
   logic [NUM_CH-1:0]    rsci_ld_core_psct;
   logic [NUM_CH-1:0]    rsci_biwt;
   logic [NUM_CH-1:0]    rsci_bdwt;
   logic [NUM_CH-1:0]    rsci_ld_core_sct;
   logic [NUM_CH*DW-1:0] core_dat;
   logic                 core_stall;

   modport slave (
      input  chn_vd, chn_dat, core_wen, core_wten,
             rsci_iswt0, rsci_oswt, rsci_ld_core_psct,
      output chn_rdy, rsci_biwt, rsci_bdwt, rsci_ld_core_sct,
             core_dat, core_stall
   );

   modport master (
      output chn_vd, chn_dat, core_wen, core_wten,
             rsci_iswt0, rsci_oswt, rsci_ld_core_psct,
      input  chn_rdy, rsci_biwt, rsci_bdwt, rsci_ld_core_sct,
             core_dat, core_stall
   );
endinterface : hls_chn_in_wait_ctrl_mc_if
`default_nettype wire

// File: rtl/hls_chn_in_fifo.sv
`default_nettype none
//==============================================================================
// Module  : hls_chn_in_fifo
// Purpose : Single-channel prefetch buffer of DEPTH entries with registered
//           ready. Pointers carry one extra wrap bit to tell full from empty.
// Ports   : clk, rst  - clock, synchronous active-high reset
//           push, din - write request (gated internally by rdy) and data
//           pop       - read request (ignored when empty)
//           rdy       - registered "can accept", low while in reset
//           empty     - buffer holds no entry
//           head      - oldest entry (stale contents when empty)
// Revision: 1.0 - initial release
//==============================================================================
module hls_chn_in_fifo
   import hls_chn_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          push,
   input  wire logic [DW-1:0] din,
   input  wire logic          pop,
   output logic               rdy,
   output logic               empty,
   output logic [DW-1:0]      head
);
   localparam int c_pw = clog2(DEPTH);

   logic [c_pw:0]   wr_ptr_q, wr_ptr_d;
   logic [c_pw:0]   rd_ptr_q, rd_ptr_d;
   logic            rdy_q, rdy_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic            push_ok, pop_ok, full_nxt;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem_q[rd_ptr_q[c_pw-1:0]];
   assign rdy   = rdy_q;

   always_comb begin
      push_ok  = push & rdy_q;
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + (c_pw+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (c_pw+1)'(pop_ok);
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[c_pw-1:0]] = din;
      end
      // Ready is registered from the next-state occupancy, so a pop frees a
      // slot that becomes visible to the producer one cycle later.
      full_nxt = (wr_ptr_d[c_pw-1:0] == rd_ptr_d[c_pw-1:0]) &&
                 (wr_ptr_d[c_pw] != rd_ptr_d[c_pw]);
      rdy_d    = ~full_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= rdy_d;
      end
   end

   // Storage needs no reset: empty/full come from the pointers alone.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule : hls_chn_in_fifo
`default_nettype wire

// File: rtl/hls_chn_in_wait_ctrl_mc.sv
`default_nettype none
//==============================================================================
// Module  : hls_chn_in_wait_ctrl_mc
// Purpose : Multi-channel input-channel wait controller. Each channel has a
//           prefetch buffer, a pending-read flag that survives stalls, and a
//           saturating stall counter.
// Ports   : nvdla_core_clk, nvdla_core_rst - clock, sync active-high reset
//           chn_if (slave)  - channel handshake and core read controls
//           stall_cnt_clr   - synchronous clear of all stall counters
//           stall_cnt       - per-channel stall counts, channel c at
//                             [c*CNT_W +: CNT_W]
// Revision: 1.0 - initial release
//==============================================================================
module hls_chn_in_wait_ctrl_mc
   import hls_chn_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DW     = 16,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  wire logic                  nvdla_core_clk,
   input  wire logic                  nvdla_core_rst,
   hls_chn_in_wait_ctrl_mc_if.slave   chn_if,
   input  wire logic                  stall_cnt_clr,
   output logic [NUM_CH*CNT_W-1:0]    stall_cnt
);
   localparam logic [CNT_W-1:0] c_sat = CNT_W'(stall_sat(CNT_W));

   logic [NUM_CH-1:0]    icwt_q, icwt_d;
   logic [NUM_CH-1:0]    ogwt, biwt, stall_hit, empty, rdy;
   logic [NUM_CH*DW-1:0] core_dat;
   logic [CNT_W-1:0]     cnt_q [NUM_CH];
   logic [CNT_W-1:0]     cnt_d [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hls_chn_in_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (nvdla_core_clk),
         .rst   (nvdla_core_rst),
         .push  (chn_if.chn_vd[c]),
         .din   (chn_if.chn_dat[c*DW +: DW]),
         .pop   (biwt[c]),
         .rdy   (rdy[c]),
         .empty (empty[c]),
         .head  (core_dat[c*DW +: DW])
      );
      assign stall_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
   end

   always_comb begin
      ogwt      = '0;
      biwt      = '0;
      stall_hit = '0;
      icwt_d    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         // A new request is masked by core_wten; an already pending one is
         // not, so the core never loses a read it has started.
         ogwt[c]      = (chn_if.rsci_iswt0[c] & ~chn_if.core_wten) | icwt_q[c];
         biwt[c]      = ogwt[c] & ~empty[c];
         stall_hit[c] = ogwt[c] & empty[c];
         icwt_d[c]    = ogwt[c] & ~biwt[c];
         cnt_d[c]     = cnt_q[c];
         if (stall_cnt_clr) begin
            cnt_d[c] = '0;
         end else if (stall_hit[c] && (cnt_q[c] != c_sat)) begin
            cnt_d[c] = cnt_q[c] + 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         icwt_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         icwt_q <= icwt_d;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign chn_if.chn_rdy          = rdy;
   assign chn_if.rsci_biwt        = biwt;
   assign chn_if.rsci_bdwt        = chn_if.rsci_oswt & {NUM_CH{chn_if.core_wen}};
   assign chn_if.rsci_ld_core_sct = chn_if.rsci_ld_core_psct & ogwt;
   assign chn_if.core_dat         = core_dat;
   assign chn_if.core_stall       = |stall_hit;
endmodule : hls_chn_in_wait_ctrl_mc
`default_nettype wire

// File: tb/tb_hls_chn_in_wait_ctrl_mc.sv
`default_nettype none
//==============================================================================
// Module  : tb_hls_chn_in_wait_ctrl_mc
// Purpose : Self-checking bench for hls_chn_in_wait_ctrl_mc: a queue-level
//           reference model compared every cycle, plus directed literal checks.
// Revision: 1.0 - initial release
//==============================================================================
module tb_hls_chn_in_wait_ctrl_mc;
   localparam int NCH   = 2;
   localparam int DW    = 16;
   localparam int DEPTH = 2;
   localparam int CW    = 4;
   localparam int SAT   = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic [NCH*CW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hls_chn_in_wait_ctrl_mc_if #(.NUM_CH(NCH), .DW(DW)) bus ();

   hls_chn_in_wait_ctrl_mc #(
      .NUM_CH (NCH),
      .DW     (DW),
      .DEPTH  (DEPTH),
      .CNT_W  (CW)
   ) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .chn_if         (bus),
      .stall_cnt_clr  (clr),
      .stall_cnt      (stall_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: per-channel FIFO contents ----------
   logic [DW-1:0] mbuf [NCH][DEPTH];
   int            mcnt [NCH];
   bit            mpend [NCH];
   int            mscnt [NCH];
   bit            m_in_rst = 1'b0;
   bit            mvalid   = 1'b0;

   // Mid-cycle: compare DUT against model for the current inputs, then advance
   // the model by the upcoming clock edge (inputs are stable until then).
   always @(negedge clk) begin : b_model
      bit og, bw, rdy_e, emp, stall_e;
      stall_e = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         emp   = (mcnt[c] == 0);
         og    = (bus.rsci_iswt0[c] & ~bus.core_wten) | mpend[c];
         bw    = og & ~emp;
         rdy_e = !m_in_rst && (mcnt[c] < DEPTH);
         if (og && emp) stall_e = 1'b1;
         if (mvalid) begin
            chk($sformatf("m_rdy[%0d]", c),  64'(bus.chn_rdy[c]),   64'(rdy_e));
            chk($sformatf("m_biwt[%0d]", c), 64'(bus.rsci_biwt[c]), 64'(bw));
            chk($sformatf("m_bdwt[%0d]", c), 64'(bus.rsci_bdwt[c]),
                64'(bus.rsci_oswt[c] & bus.core_wen));
            chk($sformatf("m_sct[%0d]", c),  64'(bus.rsci_ld_core_sct[c]),
                64'(bus.rsci_ld_core_psct[c] & og));
            chk($sformatf("m_scnt[%0d]", c), 64'(stall_cnt[c*CW +: CW]), 64'(mscnt[c]));
            if (bw) begin
               chk($sformatf("m_dat[%0d]", c), 64'(bus.core_dat[c*DW +: DW]), 64'(mbuf[c][0]));
            end
         end
      end
      if (mvalid) chk("m_stall", 64'(bus.core_stall), 64'(stall_e));

      for (int c = 0; c < NCH; c++) begin
         if (rst) begin
            mcnt[c]  = 0;
            mpend[c] = 1'b0;
            mscnt[c] = 0;
         end else begin
            emp   = (mcnt[c] == 0);
            og    = (bus.rsci_iswt0[c] & ~bus.core_wten) | mpend[c];
            bw    = og & ~emp;
            rdy_e = !m_in_rst && (mcnt[c] < DEPTH);
            if (clr) mscnt[c] = 0;
            else if (og && emp && mscnt[c] < SAT) mscnt[c] = mscnt[c] + 1;
            mpend[c] = og & ~bw;
            if (bw) begin
               for (int i = 0; i < DEPTH-1; i++) mbuf[c][i] = mbuf[c][i+1];
               mcnt[c] = mcnt[c] - 1;
            end
            if (bus.chn_vd[c] && rdy_e) begin
               mbuf[c][mcnt[c]] = bus.chn_dat[c*DW +: DW];
               mcnt[c] = mcnt[c] + 1;
            end
         end
      end
      m_in_rst = rst;
      mvalid   = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // ---------------- directed stimulus with literal expectations ----------
   initial begin
      bus.chn_vd = '0; bus.chn_dat = '0; bus.core_wen = 1'b0; bus.core_wten = 1'b0;
      bus.rsci_iswt0 = '0; bus.rsci_oswt = '0; bus.rsci_ld_core_psct = '0;
      tick(); tick();
      mid();
      chk("rst_rdy",   64'(bus.chn_rdy),    64'h0);
      chk("rst_biwt",  64'(bus.rsci_biwt),  64'h0);
      chk("rst_stall", 64'(bus.core_stall), 64'h0);
      chk("rst_cnt",   64'(stall_cnt),      64'h0);
      tick(); rst = 1'b0;
      tick(); bus.chn_vd = 2'b01; bus.chn_dat[15:0] = 16'h3C00;
      mid();  chk("rel_rdy", 64'(bus.chn_rdy), 64'h3);

      // first word delivered the cycle after it was pushed
      tick(); bus.chn_vd = 2'b00; bus.rsci_iswt0 = 2'b01;
      mid();  chk("t1_biwt", 64'(bus.rsci_biwt), 64'h1);
              chk("t1_dat",  64'(bus.core_dat[15:0]), 64'h3C00);
              chk("t1_cnt0", 64'(stall_cnt[3:0]), 64'h0);

      // pending request on ch1 spans four empty cycles
      tick(); bus.rsci_iswt0 = 2'b10;
      mid();  chk("t2_stall_a", 64'(bus.core_stall), 64'h1);
      tick(); bus.rsci_iswt0 = 2'b00;
      mid();  chk("t2_stall_b", 64'(bus.core_stall), 64'h1);
              chk("t2_biwt_b",  64'(bus.rsci_biwt),  64'h0);
      tick();
      mid();  chk("t2_stall_c", 64'(bus.core_stall), 64'h1);
      tick(); bus.chn_vd = 2'b10; bus.chn_dat[31:16] = 16'h1234;
      mid();  chk("t2_stall_d", 64'(bus.core_stall), 64'h1);
      tick(); bus.chn_vd = 2'b00;
      mid();  chk("t2_biwt", 64'(bus.rsci_biwt), 64'h2);
              chk("t2_dat",  64'(bus.core_dat[31:16]), 64'h1234);
              chk("t2_stall_e", 64'(bus.core_stall), 64'h0);
              chk("t2_cnt1", 64'(stall_cnt[7:4]), 64'h4);

      // fill DEPTH=2 buffer, hold a third word, then drain in order
      tick(); bus.chn_vd = 2'b01; bus.chn_dat[15:0] = 16'hAAAA;
      mid();  chk("t3_rdy_a", 64'(bus.chn_rdy[0]), 64'h1);
      tick(); bus.chn_dat[15:0] = 16'hBBBB;
      mid();
      tick(); bus.chn_dat[15:0] = 16'hCCCC;
      mid();  chk("t3_rdy_full", 64'(bus.chn_rdy[0]), 64'h0);
      tick(); bus.rsci_iswt0 = 2'b01;
      mid();  chk("t3_dat_a", 64'(bus.core_dat[15:0]), 64'hAAAA);
              chk("t3_rdy_b", 64'(bus.chn_rdy[0]), 64'h0);
      tick();
      mid();  chk("t3_dat_b", 64'(bus.core_dat[15:0]), 64'hBBBB);
              chk("t3_rdy_c", 64'(bus.chn_rdy[0]), 64'h1);
      tick(); bus.chn_vd = 2'b00;
      mid();  chk("t3_dat_c", 64'(bus.core_dat[15:0]), 64'hCCCC);
              chk("t3_biwt_c", 64'(bus.rsci_biwt), 64'h1);
      tick(); bus.rsci_iswt0 = 2'b00;
      mid();

      // core_wten masks new requests, not pending ones
      tick(); bus.chn_vd = 2'b01; bus.chn_dat[15:0] = 16'hDDDD;
      mid();
      tick(); bus.chn_vd = 2'b00; bus.core_wten = 1'b1; bus.rsci_iswt0 = 2'b01;
              bus.rsci_ld_core_psct = 2'b01; bus.rsci_oswt = 2'b11; bus.core_wen = 1'b1;
      mid();  chk("t4_biwt_m", 64'(bus.rsci_biwt), 64'h0);
              chk("t4_sct_m",  64'(bus.rsci_ld_core_sct), 64'h0);
              chk("t4_bdwt",   64'(bus.rsci_bdwt), 64'h3);
      tick(); bus.core_wten = 1'b0; bus.rsci_iswt0 = 2'b10; bus.rsci_ld_core_psct = 2'b00;
              bus.core_wen = 1'b0;
      mid();  chk("t4_bdwt_off", 64'(bus.rsci_bdwt), 64'h0);
              chk("t4_stall", 64'(bus.core_stall), 64'h1);
      tick(); bus.core_wten = 1'b1; bus.rsci_iswt0 = 2'b00; bus.rsci_ld_core_psct = 2'b10;
              bus.rsci_oswt = 2'b00;
      mid();  chk("t4_sct_p", 64'(bus.rsci_ld_core_sct), 64'h2);
      tick(); bus.core_wten = 1'b0; bus.rsci_ld_core_psct = 2'b00; bus.chn_vd = 2'b10;
              bus.chn_dat[31:16] = 16'h5555; bus.rsci_iswt0 = 2'b01;
      mid();  chk("t4_dat_d", 64'(bus.core_dat[15:0]), 64'hDDDD);
      tick(); bus.chn_vd = 2'b00; bus.rsci_iswt0 = 2'b00;
      mid();  chk("t4_dat_5", 64'(bus.core_dat[31:16]), 64'h5555);
              chk("t4_biwt_5", 64'(bus.rsci_biwt), 64'h2);

      // stall counter saturation and clear priority
      tick(); clr = 1'b1;
      mid();
      tick(); clr = 1'b0; bus.rsci_iswt0 = 2'b01;
      repeat (19) tick();
      tick(); clr = 1'b1;
      mid();  chk("t5_sat", 64'(stall_cnt[3:0]), 64'(SAT));
      tick(); clr = 1'b0;
      mid();  chk("t5_clr", 64'(stall_cnt[3:0]), 64'h0);
      tick(); bus.rsci_iswt0 = 2'b00; bus.chn_vd = 2'b01; bus.chn_dat[15:0] = 16'h7777;
      mid();
      tick(); bus.chn_vd = 2'b00;
      mid();  chk("t5_dat", 64'(bus.core_dat[15:0]), 64'h7777);

      // reset in mid-operation discards buffer and pending request
      tick(); bus.chn_vd = 2'b01; bus.chn_dat[15:0] = 16'hEEEE;
      mid();
      tick(); bus.chn_dat[15:0] = 16'hFFFF; bus.rsci_iswt0 = 2'b10;
      mid();
      tick(); bus.chn_vd = 2'b00; bus.rsci_iswt0 = 2'b00; rst = 1'b1;
      mid();  chk("t6_full", 64'(bus.chn_rdy[0]), 64'h0);
              chk("t6_pend", 64'(bus.core_stall), 64'h1);
      tick(); rst = 1'b0;
      mid();  chk("t6_rdy_r", 64'(bus.chn_rdy), 64'h0);
      tick(); bus.rsci_iswt0 = 2'b01;
      mid();  chk("t6_rdy",   64'(bus.chn_rdy), 64'h3);
              chk("t6_biwt",  64'(bus.rsci_biwt), 64'h0);
              chk("t6_stall", 64'(bus.core_stall), 64'h1);
              chk("t6_cnt",   64'(stall_cnt), 64'h0);
      tick(); bus.rsci_iswt0 = 2'b00;
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule : tb_hls_chn_in_wait_ctrl_mc
`default_nettype wire
